// File: rtl/cmd_frame_parser_pkg.sv
// Shared types and constants for the command frame parser.
package parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_e;

  localparam logic [1:0] ERR_OVR = 2'b00;
  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  localparam logic [7:0] SYNC_WR_DEF = 8'hA5;
  localparam logic [7:0] SYNC_ST_DEF = 8'h5A;

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-in / RAM-write-out bundle of the command frame parser.
interface cmd_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pc_start;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output rx_data, rx_valid,
    input  wr, wr_addr, wr_data, pc_start, frame_ok, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr, wr_addr, wr_data, pc_start, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/cmd_frame_parser_frame_buffer.sv
// Payload buffer: one synchronous write port, one combinational read port.
module frame_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_frame_parser.sv
// Buffers and checksums write frames, commits only valid frames to RAM,
// and decodes the one-byte start command.
module cmd_frame_parser
  import parser_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  SYNC_WR     = SYNC_WR_DEF,
  parameter logic [7:0]  SYNC_ST     = SYNC_ST_DEF
) (
  input logic              clk_Parser,
  input logic              rst,
  cmd_frame_parser_if.slave bus
);

  localparam int unsigned    AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned    TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);

  state_e        state_q;
  logic [7:0]    addr_q, sum_q, sum_d;
  logic [6:0]    len_q, idx_q;
  logic [TW-1:0] tmr_q;
  logic          wr_q, pc_start_q, frame_ok_q, frame_err_q;
  logic [7:0]    wr_addr_q, wr_data_q;
  logic [1:0]    err_code_q;
  logic          counting, timed_out, buf_we;
  logic [7:0]    buf_rdata;

  assign sum_d     = sum_q + bus.rx_data;
  assign counting  = state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK};
  // Expiry wins over a byte arriving in the same cycle: that byte dies with the frame.
  assign timed_out = counting && (tmr_q == TO_LAST);
  assign buf_we    = (state_q == S_DATA) && bus.rx_valid && !timed_out;

  frame_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk_i   (clk_Parser),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (bus.rx_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk_Parser) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pc_start_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      wr_q        <= 1'b0;
      pc_start_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (!counting || bus.rx_valid) tmr_q <= '0;
      else                           tmr_q <= tmr_q + 1'b1;

      if (timed_out) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TO;
      end else begin
        unique case (state_q)
          S_IDLE: if (bus.rx_valid) begin
            if (bus.rx_data == SYNC_WR)      state_q    <= S_ADDR;
            else if (bus.rx_data == SYNC_ST) pc_start_q <= 1'b1;
          end
          S_ADDR: if (bus.rx_valid) begin
            addr_q  <= bus.rx_data;
            sum_q   <= bus.rx_data;
            state_q <= S_LEN;
          end
          S_LEN: if (bus.rx_valid) begin
            if (bus.rx_data == '0 || bus.rx_data > MAX_LEN_B) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
              state_q     <= S_IDLE;
            end else begin
              len_q   <= bus.rx_data[6:0];
              idx_q   <= '0;
              sum_q   <= sum_d;
              state_q <= S_DATA;
            end
          end
          // Index returns to 0 on the last byte so CHK can prefetch buf[0].
          S_DATA: if (bus.rx_valid) begin
            sum_q <= sum_d;
            if (idx_q + 7'd1 == len_q) begin
              idx_q   <= '0;
              state_q <= S_CHK;
            end else begin
              idx_q <= idx_q + 7'd1;
            end
          end
          S_CHK: if (bus.rx_valid) begin
            if (bus.rx_data != sum_q) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
              state_q     <= S_IDLE;
            end else begin
              state_q   <= S_COMMIT;
              wr_q      <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= buf_rdata;
              idx_q     <= 7'd1;
            end
          end
          S_COMMIT: begin
            if (bus.rx_valid) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_OVR;
            end
            if (idx_q == len_q) begin
              state_q    <= S_IDLE;
              frame_ok_q <= 1'b1;
            end else begin
              wr_q      <= 1'b1;
              wr_addr_q <= addr_q + {1'b0, idx_q};
              wr_data_q <= buf_rdata;
              idx_q     <= idx_q + 7'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr        = wr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.pc_start  = pc_start_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: frame commit, wrap, errors, timeout, overrun, reset.
module tb_cmd_frame_parser;
  import parser_pkg::*;

  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic rst;
  cmd_frame_parser_if bus();

  cmd_frame_parser #(
    .MAX_LEN     (64),
    .TIMEOUT_CYC (TO),
    .SYNC_WR     (8'hA5),
    .SYNC_ST     (8'h5A)
  ) dut (
    .clk_Parser (clk),
    .rst        (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int n_wr = 0, n_err = 0, n_ok = 0;
  logic [7:0] pl [64];

  always @(negedge clk) begin
    if (bus.wr === 1'b1)        n_wr++;
    if (bus.frame_err === 1'b1) n_err++;
    if (bus.frame_ok === 1'b1)  n_ok++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pl[i]);
    send_byte(chk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    checks++;
    if ({bus.wr, bus.pc_start, bus.frame_ok, bus.frame_err, bus.busy} !== 5'b0)
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.wr, bus.pc_start, bus.frame_ok, bus.frame_err, bus.busy});
    else passed++;
    checks++;
    if ({bus.wr_addr, bus.wr_data, bus.err_code} !== 18'h0)
      $display("FAIL reset_data: got %h expected 0", {bus.wr_addr, bus.wr_data, bus.err_code});
    else passed++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic;
    int e0;
    e0 = n_err;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h10, 3, 8'h79);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h10, 8'h11})
      $display("FAIL basic_w0: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, 8'h10, 8'h11});
    else passed++;
    step(1);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h11, 8'h22})
      $display("FAIL basic_w1: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, 8'h11, 8'h22});
    else passed++;
    step(1);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h12, 8'h33})
      $display("FAIL basic_w2: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, 8'h12, 8'h33});
    else passed++;
    step(1);
    checks++;
    if ({bus.wr, bus.frame_ok, bus.busy} !== 3'b010)
      $display("FAIL basic_done: got %b expected 010", {bus.wr, bus.frame_ok, bus.busy});
    else passed++;
    checks++;
    if (n_err !== e0) $display("FAIL basic_noerr: got %0d expected %0d", n_err, e0);
    else passed++;
  endtask

  task automatic test_wrap;
    logic [7:0] ea;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame(8'hFE, 3, 8'h07);
    for (int i = 0; i < 3; i++) begin
      ea = 8'hFE + 8'(i);
      checks++;
      if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, ea, pl[i]})
        $display("FAIL wrap_w%0d: got %h expected %h", i, {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, ea, pl[i]});
      else passed++;
      step(1);
    end
    checks++;
    if (bus.frame_ok !== 1'b1) $display("FAIL wrap_ok: got %b expected 1", bus.frame_ok);
    else passed++;
  endtask

  task automatic test_bad_chk;
    int w0;
    w0 = n_wr;
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    send_frame(8'h10, 2, 8'h00);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.busy, bus.wr} !== {1'b1, ERR_CHK, 1'b0, 1'b0})
      $display("FAIL chk_err: got %b expected 10100", {bus.frame_err, bus.err_code, bus.busy, bus.wr});
    else passed++;
    // Recovery frame whose payload equals the start byte: must be plain data.
    pl[0] = 8'h5A;
    send_frame(8'h20, 1, 8'h7B);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data, bus.pc_start} !== {1'b1, 8'h20, 8'h5A, 1'b0})
      $display("FAIL chk_recover: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data, bus.pc_start}, {1'b1, 8'h20, 8'h5A, 1'b0});
    else passed++;
    step(1);
    checks++;
    if ({bus.frame_ok, n_wr} !== {1'b1, w0 + 1})
      $display("FAIL chk_recover_ok: got ok=%b wr=%0d expected ok=1 wr=%0d", bus.frame_ok, n_wr, w0 + 1);
    else passed++;
  endtask

  task automatic test_len;
    int w0;
    w0 = n_wr;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.busy} !== {1'b1, ERR_LEN, 1'b0})
      $display("FAIL len_zero: got %b expected 1100", {bus.frame_err, bus.err_code, bus.busy});
    else passed++;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h41);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.busy} !== {1'b1, ERR_LEN, 1'b0})
      $display("FAIL len_big: got %b expected 1100", {bus.frame_err, bus.err_code, bus.busy});
    else passed++;
    step(2);
    checks++;
    if (n_wr !== w0) $display("FAIL len_nowr: got %0d expected %0d", n_wr, w0);
    else passed++;
  endtask

  task automatic test_timeout;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
    step(TO - 1);
    checks++;
    if ({bus.frame_err, bus.busy} !== 2'b01)
      $display("FAIL to_early: got %b expected 01", {bus.frame_err, bus.busy});
    else passed++;
    step(1);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.busy} !== {1'b1, ERR_TO, 1'b0})
      $display("FAIL to_fire: got %b expected 1110", {bus.frame_err, bus.err_code, bus.busy});
    else passed++;
    send_byte(8'h5A);
    checks++;
    if (bus.pc_start !== 1'b1) $display("FAIL to_start: got %b expected 1", bus.pc_start);
    else passed++;
    step(1);
    checks++;
    if (bus.pc_start !== 1'b0) $display("FAIL to_start_pulse: got %b expected 0", bus.pc_start);
    else passed++;
    // A start byte landing on the expiry cycle is discarded, not decoded.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
    step(TO - 1);
    send_byte(8'h5A);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.pc_start, bus.busy} !== {1'b1, ERR_TO, 1'b0, 1'b0})
      $display("FAIL to_same_cycle: got %b expected 11100", {bus.frame_err, bus.err_code, bus.pc_start, bus.busy});
    else passed++;
    step(1);
    checks++;
    if (bus.pc_start !== 1'b0) $display("FAIL to_discard: got %b expected 0", bus.pc_start);
    else passed++;
  endtask

  task automatic test_back_to_back;
    pl[0] = 8'h44;
    send_frame(8'h30, 1, 8'h75);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h30, 8'h44})
      $display("FAIL b2b_w: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, 8'h30, 8'h44});
    else passed++;
    step(1);
    checks++;
    if (bus.frame_ok !== 1'b1) $display("FAIL b2b_ok: got %b expected 1", bus.frame_ok);
    else passed++;
    send_byte(8'h5A);
    checks++;
    if ({bus.pc_start, bus.busy} !== 2'b10)
      $display("FAIL b2b_start: got %b expected 10", {bus.pc_start, bus.busy});
    else passed++;
  endtask

  task automatic fill_long(output logic [7:0] chk);
    chk = 8'h80 + 8'h40;
    for (int i = 0; i < 64; i++) begin
      pl[i] = 8'(i + 1);
      chk   = chk + pl[i];
    end
  endtask

  task automatic test_overrun;
    logic [7:0] chk, ea;
    int e0, k0;
    fill_long(chk);
    e0 = n_err;
    k0 = n_ok;
    send_frame(8'h80, 64, chk);
    for (int i = 0; i < 64; i++) begin
      ea = 8'h80 + 8'(i);
      checks++;
      if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, ea, pl[i]})
        $display("FAIL ovr_w%0d: got %h expected %h", i, {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, ea, pl[i]});
      else passed++;
      if (i == 21) begin
        checks++;
        if ({bus.frame_err, bus.err_code} !== {1'b1, ERR_OVR})
          $display("FAIL ovr_err: got %b expected 100", {bus.frame_err, bus.err_code});
        else passed++;
      end
      if (i == 20) begin
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
      end
      step(1);
      bus.rx_valid = 1'b0;
    end
    checks++;
    if ({bus.wr, bus.frame_ok, bus.busy, bus.frame_err} !== 4'b0100)
      $display("FAIL ovr_done: got %b expected 0100", {bus.wr, bus.frame_ok, bus.busy, bus.frame_err});
    else passed++;
    step(1);
    checks++;
    if ({n_err, n_ok, 31'(bus.busy)} !== {e0 + 1, k0 + 1, 31'd0})
      $display("FAIL ovr_counts: got err=%0d ok=%0d busy=%b expected err=%0d ok=%0d busy=0",
               n_err, n_ok, bus.busy, e0 + 1, k0 + 1);
    else passed++;
  endtask

  task automatic test_reset_commit;
    logic [7:0] chk;
    int w0, k0;
    fill_long(chk);
    k0 = n_ok;
    send_frame(8'h80, 64, chk);
    step(9);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h89, 8'h0A})
      $display("FAIL rstc_w9: got %h expected %h", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, 8'h89, 8'h0A});
    else passed++;
    rst = 1'b1;
    step(1);
    checks++;
    if ({bus.wr, bus.wr_addr, bus.wr_data, bus.frame_ok, bus.frame_err, bus.busy} !== 20'h0)
      $display("FAIL rstc_zero: got %h expected 0",
               {bus.wr, bus.wr_addr, bus.wr_data, bus.frame_ok, bus.frame_err, bus.busy});
    else passed++;
    rst = 1'b0;
    w0 = n_wr;
    step(80);
    checks++;
    if ({n_wr, n_ok} !== {w0, k0})
      $display("FAIL rstc_abort: got wr=%0d ok=%0d expected wr=%0d ok=%0d", n_wr, n_ok, w0, k0);
    else passed++;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_bad_chk();
    test_len();
    test_timeout();
    test_back_to_back();
    step(2);
    test_overrun();
    test_reset_commit();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
